alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter N, default 8, operand width in bits (N >= 2, power of two).
REQ-002 Parameter M, default 16, result width in bits; SHALL satisfy M >= 2*N, checked at elaboration.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request present on A/B/sel.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 A  input  N  operand A, unsigned.
REQ-008 B  input  N  operand B, unsigned.
REQ-009 sel  input  3  opcode.
REQ-010 out_valid  output  1  out/zero hold a completed result.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out  output  M  result.
REQ-013 zero  output  1  high when out == 0 while out_valid is high.
REQ-014 busy  output  1  high in EXEC state (multi-cycle multiply in progress).

Function
REQ-015 The request handshake SHALL complete on a cycle where in_valid && in_ready; A/B/sel SHALL be captured on that edge.
REQ-016 The result handshake SHALL complete on a cycle where out_valid && out_ready.
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC, DONE; in_ready SHALL be high only in IDLE.
REQ-018 IDLE -> DONE on accept with sel != 3'b111; IDLE -> EXEC on accept with sel == 3'b111.
REQ-019 EXEC SHALL last exactly N cycles (one shift-add step per cycle), then go to DONE.
REQ-020 DONE -> IDLE on result handshake; otherwise DONE SHALL hold, with out and zero stable.
REQ-021 Latency: non-multiply ops SHALL assert out_valid on the cycle after accept; multiply SHALL assert out_valid N+1 cycles after accept.
REQ-022 At most one operation SHALL be outstanding; a new request SHALL NOT be accepted in the cycle of the result handshake (IDLE is re-entered first).
REQ-023 sel 000 ADD: out = A + B, zero-extended to M bits, with carry in bit N.
REQ-024 sel 001 SUB: out[N-1:0] = (A - B) mod 2^N; out[N] = 1 iff A < B (borrow); bits above N are 0.
REQ-025 sel 010 AND, 011 OR, 100 XOR: bitwise on N bits, zero-extended.
REQ-026 sel 101 SHL: out = A zero-extended to M bits, shifted left by B[log2(N)-1:0]; no truncation to N bits.
REQ-027 sel 110 SHR: out = A logically shifted right by B[log2(N)-1:0], zero-extended.
REQ-028 sel 111 MUL: out = full 2N-bit unsigned product A*B, zero-extended to M bits.
REQ-029 Upper bits of B SHALL be ignored for shifts.
REQ-030 out and zero SHALL be registered and change only on a transition into DONE.
REQ-031 In IDLE and EXEC, out SHALL retain its last value; zero SHALL be 0 whenever out_valid is 0.
REQ-032 in_valid while in EXEC or DONE SHALL have no effect; inputs SHALL NOT be sampled.

Reset
REQ-033 While rst is high at a clock edge: state SHALL be IDLE, out = 0, out_valid = 0, zero = 0, busy = 0, and any internal multiply accumulator/counter SHALL be 0.
REQ-034 in_ready SHALL be 0 in any cycle where rst is high, and 1 on the first cycle after rst deasserts.
REQ-035 rst asserted mid-EXEC or in DONE SHALL abort the operation; no out_valid SHALL be produced for it.

Verification
REQ-036 ADD: A=0x0A, B=0x02, sel=000 accepted at cycle k -> out_valid at k+1, out=0x000C, zero=0.
REQ-037 SUB borrow: A=0x03, B=0x05, sel=001 -> out=0x01FE; then A=0x07, B=0x07 -> out=0x0000, zero=1.
REQ-038 MUL: A=0xFF, B=0xFF, sel=111 accepted at k -> busy high for k+1..k+8, out_valid at k+9, out=0xFE01.
REQ-039 SHL/SHR: A=0x81, B=0xF3, sel=101 -> out=0x0408; sel=110 -> out=0x0010.
REQ-040 Backpressure: out_ready held 0 for 5 cycles after ADD result -> out_valid, out, zero stable, in_ready=0; in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-041 Reset mid-MUL: rst pulsed on 4th EXEC cycle -> next cycle out_valid=0, out=0, busy=0, in_ready=1 after rst low; following ADD 0x01+0x01 -> out=0x0002.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Request/result handshake bundle for alu_pipe: operands and opcode in, result and status out.
// master drives requests and consumes results; slave is the ALU.
interface alu_pipe_if #(
    parameter int N = 8,
    parameter int M = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out;
    logic         zero;
    logic         busy;

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, out, zero, busy
    );

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, out, zero, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-outstanding ALU: add/sub/logic/shift complete in 1 cycle, multiply is N-cycle shift-add.
// Result is held in DONE until out_ready; no new request is taken until IDLE is re-entered.
module alu_pipe #(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  io_bus
);
    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);

    if (M < 2 * N) begin : g_width_check
        $error("alu_pipe: M must be at least 2*N");
    end
    if (N < 2 || (N & (N - 1)) != 0) begin : g_n_check
        $error("alu_pipe: N must be a power of two >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t        r_state;
    logic          r_in_rdy;
    logic          r_out_vld;
    logic          r_busy;
    logic          r_zero;
    logic [M-1:0]  r_out;
    logic [M-1:0]  r_acc;
    logic [M-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [SW-1:0] r_cnt;

    logic          w_accept;
    logic [SW-1:0] w_sh;
    logic [N:0]    w_sum;
    logic [N:0]    w_diff;
    logic [M-1:0]  w_res;
    logic [M-1:0]  w_acc_nxt;

    assign w_accept = io_bus.in_valid && io_bus.in_ready;
    assign w_sh     = io_bus.B[SW-1:0];
    assign w_sum    = {1'b0, io_bus.A} + {1'b0, io_bus.B};
    // The extra top bit of an (N+1)-bit subtract is exactly the borrow.
    assign w_diff   = {1'b0, io_bus.A} - {1'b0, io_bus.B};

    always_comb begin
        w_res = '0;
        case (io_bus.sel)
            3'b000:  w_res = M'(w_sum);
            3'b001:  w_res = M'(w_diff);
            3'b010:  w_res = M'(io_bus.A & io_bus.B);
            3'b011:  w_res = M'(io_bus.A | io_bus.B);
            3'b100:  w_res = M'(io_bus.A ^ io_bus.B);
            3'b101:  w_res = M'(io_bus.A) << w_sh;
            3'b110:  w_res = M'(io_bus.A >> w_sh);
            default: w_res = '0;
        endcase
    end

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_zero    <= 1'b0;
            r_out     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_rdy <= 1'b0;
                        if (io_bus.sel == 3'b111) begin
                            r_state  <= S_EXEC;
                            r_busy   <= 1'b1;
                            r_acc    <= '0;
                            r_mcand  <= M'(io_bus.A);
                            r_mplier <= io_bus.B;
                            r_cnt    <= '0;
                        end else begin
                            r_state   <= S_DONE;
                            r_out     <= w_res;
                            r_zero    <= (w_res == '0);
                            r_out_vld <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_out     <= w_acc_nxt;
                        r_zero    <= (w_acc_nxt == '0);
                        r_out_vld <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (io_bus.out_ready) begin
                        r_state   <= S_IDLE;
                        r_out_vld <= 1'b0;
                        r_zero    <= 1'b0;
                        r_in_rdy  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_in_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_rdy && !rst;
    assign io_bus.out_valid = r_out_vld;
    assign io_bus.out       = r_out;
    assign io_bus.zero      = r_zero;
    assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe, checked against an arithmetic reference model.
module tb_alu_pipe;
    localparam int N = 8;
    localparam int M = 16;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_pipe_if #(.N(N), .M(M)) bus ();

    alu_pipe #(.N(N), .M(M)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [M-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] s);
        int unsigned ai = 32'(a);
        int unsigned bi = 32'(b);
        int unsigned sh = bi % N;
        int unsigned r  = 0;
        case (s)
            3'd0: r = ai + bi;
            3'd1: r = (ai >= bi) ? (ai - bi) : (ai + 2 * (2 ** N) - bi);
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: r = ai * (2 ** sh);
            3'd6: r = ai / (2 ** sh);
            default: r = ai * bi;
        endcase
        return r[M-1:0];
    endfunction

    // Issue one request, wait (bounded) for the result, then complete the handshake.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] s,
                          output int lat, output logic [M-1:0] res, output logic z,
                          output int busy_cycles);
        bus.A = a; bus.B = b; bus.sel = s; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1; busy_cycles = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        res = bus.out; z = bus.zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.sel = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h expected 0000", bus.out); end
        n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", bus.zero); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        rst = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        int lat; int bc; logic [M-1:0] res; logic z;
        run_op(8'h0A, 8'h02, 3'b000, lat, res, z, bc);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_checks++; if (res !== 16'h000C || z !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h/%b expected 000C/0", res, z); end
        run_op(8'h03, 8'h05, 3'b001, lat, res, z, bc);
        n_checks++; if (res !== 16'h01FE || z !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: got %h/%b expected 01FE/0", res, z); end
        run_op(8'h07, 8'h07, 3'b001, lat, res, z, bc);
        n_checks++; if (res !== 16'h0000 || z !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %h/%b expected 0000/1", res, z); end
        run_op(8'h81, 8'hF3, 3'b101, lat, res, z, bc);
        n_checks++; if (res !== 16'h0408) begin n_fail++; $display("FAIL shl: got %h expected 0408", res); end
        run_op(8'h81, 8'hF3, 3'b110, lat, res, z, bc);
        n_checks++; if (res !== 16'h0010) begin n_fail++; $display("FAIL shr: got %h expected 0010", res); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_mul();
        int lat; int bc; logic [M-1:0] res; logic z;
        run_op(8'hFF, 8'hFF, 3'b111, lat, res, z, bc);
        n_checks++; if (lat !== N + 1) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, N + 1); end
        n_checks++; if (bc !== N) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected %0d", bc, N); end
        n_checks++; if (res !== 16'hFE01 || z !== 1'b0) begin n_fail++; $display("FAIL mul_ff: got %h/%b expected FE01/0", res, z); end
        run_op(8'h00, 8'h9C, 3'b111, lat, res, z, bc);
        n_checks++; if (res !== 16'h0000 || z !== 1'b1) begin n_fail++; $display("FAIL mul_zero: got %h/%b expected 0000/1", res, z); end
    endtask

    task automatic test_random();
        int lat; int bc; logic [M-1:0] res; logic z; logic [M-1:0] exp;
        logic [N-1:0] a; logic [N-1:0] b; logic [2:0] s;
        for (int i = 0; i < 150; i++) begin
            a = N'($urandom); b = N'($urandom); s = 3'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            exp = model(a, b, s);
            run_op(a, b, s, lat, res, z, bc);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL rand_out[%0d] a=%h b=%h sel=%0d: got %h expected %h", i, a, b, s, res, exp); end
            n_checks++; if (z !== (exp == '0)) begin n_fail++; $display("FAIL rand_zero[%0d]: got %b expected %b", i, z, exp == '0); end
            n_checks++; if (lat !== ((s == 3'b111) ? N + 1 : 1)) begin n_fail++; $display("FAIL rand_latency[%0d] sel=%0d: got %0d", i, s, lat); end
        end
    endtask

    task automatic test_backpressure();
        bus.A = 8'h0A; bus.B = 8'h02; bus.sel = 3'b000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 8'h55; bus.B = 8'h66; bus.sel = 3'b011;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== 16'h000C || bus.zero !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b out=%h zero=%b in_ready=%b expected 1/000C/0/0",
                         i, bus.out_valid, bus.out, bus.zero, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'h0077) begin n_fail++; $display("FAIL bp_next_op: valid=%b out=%h expected 1/0077", bus.out_valid, bus.out); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int lat; int bc; logic [M-1:0] res; logic z; int seen;
        run_op(8'h01, 8'h02, 3'b000, lat, res, z, bc);
        bus.A = 8'hFF; bus.B = 8'hFF; bus.sel = 3'b111; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_mul_busy: got %b expected 1", bus.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || bus.busy !== 1'b0 || bus.zero !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: valid=%b out=%h busy=%b zero=%b expected 0/0000/0/0", bus.out_valid, bus.out, bus.busy, bus.zero);
        end
        rst = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result: out_valid seen %0d cycles expected 0", seen); end
        run_op(8'h01, 8'h01, 3'b000, lat, res, z, bc);
        n_checks++; if (res !== 16'h0002 || lat !== 1) begin n_fail++; $display("FAIL post_abort_add: got %h lat %0d expected 0002 lat 1", res, lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
